clk_period_meter: RTL and testbench

//   Receive-side checker for the divided clocks from the master-clock divider
//   (pixel, 7-segment and render clocks). Samples one divided clock, measures
//   its period in master-clock cycles and delivers each measurement over a

---
 rtl/clk_period_meter.sv | 180 ++++++++++++++++++
 tb/tb_clk_period_meter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Receive-side checker for one divided clock (pixel, 7-segment or render
//   clock). tick_in is synchronised into the clk domain, its rising edges are
//   detected, and the number of clk cycles between consecutive rising edges
//   is delivered as a measurement over a valid/ready port. The block also
//   tracks the smallest and largest period seen, flags an input that has
//   stopped toggling, and flags measurements that were overwritten unread.
//
// Ports
//   clk           in   1      master clock
//   clr_n         in   1      asynchronous reset, active-low
//   tick_in       in   1      divided clock under test, asynchronous to clk
//   en            in   1      measurement enable
//   stat_clr      in   1      synchronous clear of min/max/overrun
//   period        out  CNT_W  last measured period, in clk cycles
//   period_valid  out  1      period holds an unread measurement
//   period_ready  in   1      consumer accepts period this cycle
//   min_period    out  CNT_W  smallest period since reset/stat_clr
//   max_period    out  CNT_W  largest period since reset/stat_clr
//   stuck         out  1      no rising edge for TIMEOUT cycles
//   overrun       out  1      sticky: a measurement overwrote an unread one

module clk_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1048576
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             tick_in,
    input  logic             en,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic             stuck,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             capture;
    logic             stuck_set;
    logic             stuck_clr;

    // Two flops bring tick_in into the clk domain; the third holds the
    // previous synchronised level so a rising edge lasts exactly one cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= tick_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // State and period counter registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The first rise after arming only starts the count, since the time
    // before it is unknown. In MEASURE the counter restarts at 1 on each
    // rise, so at the next rise it holds the full rise-to-rise distance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        stuck_set = 1'b0;
        stuck_clr = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                    cnt_nxt   = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_W'(1);
                        stuck_clr = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        capture   = 1'b1;
                        cnt_nxt   = CNT_W'(1);
                        stuck_clr = 1'b1;
                    end else if (cnt == TIMEOUT_V) begin
                        stuck_set = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ARM;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Result delivery and statistics. A capture always loads period and
    // keeps valid high; overrun only records that an unread value was lost.
    // stat_clr takes priority over the statistics of a same-cycle capture
    // but not over the delivery of that capture.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            period       <= '0;
            period_valid <= 1'b0;
            min_period   <= '1;
            max_period   <= '0;
            stuck        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (!en) begin
                period_valid <= 1'b0;
            end else if (capture) begin
                period       <= cnt;
                period_valid <= 1'b1;
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end

            if (stuck_set) begin
                stuck <= 1'b1;
            end else if (stuck_clr) begin
                stuck <= 1'b0;
            end

            if (stat_clr) begin
                min_period <= '1;
                max_period <= '0;
                overrun    <= 1'b0;
            end else if (capture) begin
                if (cnt < min_period) begin
                    min_period <= cnt;
                end
                if (cnt > max_period) begin
                    max_period <= cnt;
                end
                if (period_valid && !period_ready) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
//   Self-checking bench for clk_period_meter. A tick generator plays a queue
//   of tick periods (each entry: one rising edge, then high for p/2 cycles and
//   low for the rest); n entries produce n rises and n-1 measurable periods.
//   Expected periods are queued when stimulus is issued and popped whenever
//   the DUT hands a result over (valid & ready).

module tb_clk_period_meter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             tick_in = 1'b0;
    logic             en;
    logic             stat_clr;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             period_ready;
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;
    logic             stuck;
    logic             overrun;

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;
    int lastRiseCycle = 0;
    bit checkLat = 1'b0;
    bit prevValid = 1'b0;

    int genQ[$];
    int expQ[$];

    clk_period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .tick_in     (tick_in),
        .en          (en),
        .stat_clr    (stat_clr),
        .period      (period),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .min_period  (min_period),
        .max_period  (max_period),
        .stuck       (stuck),
        .overrun     (overrun)
    );

    // 10 ns master clock.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input int n);
        for (int i = 0; i < n; i++) genQ.push_back(p);
    endtask

    task automatic expectPeriods(input int p, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(p);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((genQ.size() > 0 || expQ.size() > 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(genQ.size() + expQ.size()), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic waitValid();
        int n = 0;
        while (!period_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid seen", 32'(period_valid), 1);
    endtask

    task automatic rearm();
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
    endtask

    // Tick generator: drives edges 3 ns after a clk edge, so tick_in is
    // never aligned with the sampling edge.
    always begin
        int p;
        @(posedge clk);
        if (genQ.size() > 0) begin
            p = genQ.pop_front();
            #3 tick_in = 1'b1;
            lastRiseCycle = cycleCount;
            repeat (p / 2) @(posedge clk);
            #3 tick_in = 1'b0;
            repeat (p - p / 2 - 1) @(posedge clk);
        end
    end

    // Scoreboard monitor: every handshake transfer must match the oldest
    // expected period; optionally checks valid rises 3 cycles after a tick edge.
    always @(negedge clk) begin
        if (clr_n && period_valid && period_ready) begin
            if (expQ.size() > 0) begin
                checkOutput("period", period, 32'(expQ.pop_front()));
            end else begin
                checkOutput("expected queue at transfer", 32'(expQ.size()), 1);
            end
        end
        if (checkLat && period_valid && !prevValid) begin
            checkOutput("valid latency", 32'(cycleCount - lastRiseCycle), 3);
        end
        prevValid = period_valid;
    end

    initial begin
        clr_n        = 1'b0;
        en           = 1'b0;
        stat_clr     = 1'b0;
        period_ready = 1'b0;
        #23 clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values.
        checkOutput("reset period", period, 0);
        checkOutput("reset valid", 32'(period_valid), 0);
        checkOutput("reset min", min_period, 32'hFFFF_FFFF);
        checkOutput("reset max", max_period, 0);
        checkOutput("reset stuck", 32'(stuck), 0);
        checkOutput("reset overrun", 32'(overrun), 0);

        // Period 4 with ready held high.
        @(posedge clk); #1 en = 1'b1; period_ready = 1'b1;
        expectPeriods(4, 5);
        applyStimulus(4, 6);
        waitDrain();
        checkOutput("t1 min", min_period, 4);
        checkOutput("t1 max", max_period, 4);
        checkOutput("t1 overrun", 32'(overrun), 0);

        // Period 10: arming edge gives no output, valid latency checked.
        @(posedge clk); #1 en = 1'b0; stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0; en = 1'b1; checkLat = 1'b1;
        expectPeriods(10, 2);
        applyStimulus(10, 3);
        @(posedge clk);
        repeat (8) @(negedge clk);
        checkOutput("t2 arm edge no output", 32'(period_valid), 0);
        waitDrain();
        checkLat = 1'b0;
        checkOutput("t2 min", min_period, 10);
        checkOutput("t2 max", max_period, 10);

        // Two unread captures: overwrite and overrun, then stat_clr.
        @(posedge clk); #1 period_ready = 1'b0;
        rearm();
        applyStimulus(8, 1);
        applyStimulus(12, 1);
        applyStimulus(4, 1);
        waitDrain();
        checkOutput("t3 period", period, 12);
        checkOutput("t3 valid", 32'(period_valid), 1);
        checkOutput("t3 overrun", 32'(overrun), 1);
        checkOutput("t3 min", min_period, 8);
        checkOutput("t3 max", max_period, 12);
        expectPeriods(12, 1);
        @(posedge clk); #1 period_ready = 1'b1;
        waitDrain();
        checkOutput("t3 valid after read", 32'(period_valid), 0);
        @(posedge clk); #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("t3 clr overrun", 32'(overrun), 0);
        checkOutput("t3 clr min", min_period, 32'hFFFF_FFFF);
        checkOutput("t3 clr max", max_period, 0);

        // Stalled input: stuck asserts 64 cycles after the detected rise.
        rearm();
        expectPeriods(10, 1);
        applyStimulus(10, 2);
        waitDrain();
        while (cycleCount < lastRiseCycle + 40) @(negedge clk);
        checkOutput("t4 stuck early", 32'(stuck), 0);
        for (int n = 0; n < 200 && !stuck; n++) @(negedge clk);
        checkOutput("t4 stuck delay", 32'(cycleCount - lastRiseCycle), 3 + TIMEOUT);
        expectPeriods(10, 1);
        applyStimulus(10, 2);
        waitDrain();
        checkOutput("t4 stuck cleared", 32'(stuck), 0);

        // Enable dropped while a result is pending.
        @(posedge clk); #1 period_ready = 1'b0;
        rearm();
        applyStimulus(10, 2);
        waitValid();
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5 valid after en drop", 32'(period_valid), 0);
        checkOutput("t5 min kept", min_period, 10);
        checkOutput("t5 max kept", max_period, 10);
        checkOutput("t5 overrun", 32'(overrun), 0);
        @(posedge clk); #1 en = 1'b1; period_ready = 1'b1;
        expectPeriods(10, 2);
        applyStimulus(10, 3);
        @(posedge clk);
        repeat (8) @(negedge clk);
        checkOutput("t5 rearm no output", 32'(period_valid), 0);
        waitDrain();

        // Asynchronous reset in the middle of a measurement.
        @(posedge clk); #1 period_ready = 1'b0;
        rearm();
        applyStimulus(10, 3);
        waitDrain();
        repeat (5) @(negedge clk);
        checkOutput("t6 overrun before reset", 32'(overrun), 1);
        @(posedge clk); #4 clr_n = 1'b0;
        #1;
        checkOutput("t6 async period", period, 0);
        checkOutput("t6 async valid", 32'(period_valid), 0);
        checkOutput("t6 async min", min_period, 32'hFFFF_FFFF);
        checkOutput("t6 async max", max_period, 0);
        checkOutput("t6 async stuck", 32'(stuck), 0);
        checkOutput("t6 async overrun", 32'(overrun), 0);
        @(negedge clk); #2 clr_n = 1'b1;
        @(posedge clk); #1 period_ready = 1'b1;
        expectPeriods(6, 2);
        applyStimulus(6, 3);
        waitDrain();
        checkOutput("t6 min", min_period, 6);
        checkOutput("t6 max", max_period, 6);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
